shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
Round-robin arbiter that shares one DW-bit register (the shared resource) among NREQ requesters. Each requester raises req, waits for its one-hot gnt, writes through its own wr_en/wr_data lane while granted, then drops req. Hold time per grant is bounded by MAX_HOLD, so no requester can starve the others. Sits between requester logic and the shared storage; it is the only driver of shared_q.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, width of shared register and each data lane
MAX_HOLD, 8, maximum cycles a grant is held before forced release (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  request per requester, level
wr_en  input  NREQ  write strobe per requester
wr_data  input  NREQ*DW  packed data lanes, lane i = bits [i*DW +: DW]
gnt  output  NREQ  one-hot grant (all zero when idle), registered
busy  output  1  high while any grant held, registered
shared_q  output  DW  shared register contents
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset (async, any time incl. mid-grant): gnt=0, busy=0, shared_q=0, timeout=0, state=IDLE, priority pointer ptr=0, hold counter=0. Effective immediately, no clock needed.
- States: IDLE, GRANT.
- IDLE: if any req bit high, select first i with req[i]=1 searching ptr, ptr+1, ... wrapping mod NREQ. Next edge: gnt=onehot(i), busy=1, hold=0, state=GRANT. Latency req->gnt = 1 cycle. No req: stay IDLE, outputs unchanged.
- GRANT (owner i): each edge with wr_en[i]=1 loads shared_q <= lane i. wr_en from non-owners ignored always. wr_en with gnt all zero ignored. hold increments each cycle in GRANT.
- Normal release: req[i]=0 sampled at edge -> gnt=0, busy=0, state=IDLE, ptr=(i+1) mod NREQ. A write with wr_en[i]=1 on that same cycle is still accepted (gnt still high that cycle).
- Forced release: req[i]=1 and hold==MAX_HOLD-1 -> same transitions as normal release plus timeout=1 for exactly one cycle. Write on that cycle accepted.
- Simultaneous req drop and hold limit: treated as normal release, timeout stays 0.
- After any release, gnt is zero for at least one cycle (IDLE gap) before the next grant; back-to-back grants are therefore 1 idle cycle apart.
- Pointer wrap: owner NREQ-1 releases -> ptr=0.
- Requester that was force-released and keeps req high re-enters arbitration with lowest priority (ptr has moved past it).
- gnt is always zero or one-hot; busy == |gnt at all times.
- req changes while in GRANT from non-owners have no effect until IDLE.

Test Plan:
- Reset mid-grant: grant req[2], assert rst asynchronously between edges -> gnt=0, busy=0, shared_q=0 immediately; after release ptr=0, req=4'b0110 grants 4'b0010.
- Single requester: req=4'b0001, wr_en[0]=1 data 8'hA5 for one cycle, then req drop -> gnt=4'b0001 one cycle after req, shared_q=8'hA5, gnt=0 one cycle after drop, timeout never asserted.
- Round robin: req=4'b1111 held, each owner drops req after 2 cycles then re-raises -> grant order 0,1,2,3,0 with one idle cycle between grants.
- Forced release: req[1] held high 20 cycles, MAX_HOLD=8 -> gnt[1] high exactly 8 cycles, timeout pulse 1 cycle coincident with gnt drop, with req[3]=1 next grant goes to 3, not 1.
- Non-owner write blocked: gnt=4'b0100, wr_en=4'b1001 lanes 0/3 = 8'h11/8'h33 -> shared_q unchanged; wr_en[2] with 8'h7E -> shared_q=8'h7E.
- Simultaneous drop and limit: owner drops req on hold==MAX_HOLD-1 -> gnt=0 next edge, timeout remains 0.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that time-shares one DW-bit register among NREQ requesters.
// Each grant lasts at most MAX_HOLD cycles; a forced release pulses timeout.
module shared_reg_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wr_en,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [DW-1:0]     shared_q,
    output logic              timeout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [HW-1:0]   hold, hold_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            busy_nxt;
    logic [DW-1:0]   shared_nxt;
    logic            timeout_nxt;

    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr_after;
    logic [PW-1:0]   pick;
    logic            found;

    always_comb begin
        owner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) owner = PW'(i);
        end
    end

    assign ptr_after = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;

    // Search starts at ptr and wraps, so the last owner has lowest priority.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold;
        gnt_nxt     = gnt;
        busy_nxt    = busy;
        shared_nxt  = shared_q;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = NREQ'(1) << pick;
                    busy_nxt  = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (wr_en[owner]) shared_nxt = wr_data[int'(owner)*DW +: DW];
                // A dropped request wins over the hold limit, so no timeout then.
                if (!req[owner] || hold == HOLD_LAST) begin
                    gnt_nxt     = '0;
                    busy_nxt    = 1'b0;
                    ptr_nxt     = ptr_after;
                    timeout_nxt = req[owner];
                    state_nxt   = IDLE;
                end else begin
                    hold_nxt = hold + 1'b1;
                end
            end
            default: begin
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold     <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            shared_q <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold     <= hold_nxt;
            gnt      <= gnt_nxt;
            busy     <= busy_nxt;
            shared_q <= shared_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: a cycle model queues expected outputs
// per edge, plus directed checks on grant order, hold length and write blocking.
module tb_shared_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 8;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   wr_en;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [DW-1:0]     shared_q;
    logic              timeout;

    shared_reg_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .gnt      (gnt),
        .busy     (busy),
        .shared_q (shared_q),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic [DW-1:0]   q;
        logic            to;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int              m_owner;
    int              m_ptr;
    int              m_hold;
    logic [DW-1:0]   m_q;
    logic            m_to;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_q     = '0;
        m_to    = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        exp_t e;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_hold  = 0;
                end
            end
        end else begin
            if (wr_en[m_owner]) m_q = wr_data[m_owner*DW +: DW];
            if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else if (m_hold == MAX_HOLD - 1) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_hold++;
            end
        end
        e.gnt  = (m_owner < 0) ? '0 : NREQ'(1) << m_owner;
        e.busy = (m_owner >= 0);
        e.q    = m_q;
        e.to   = m_to;
        exp_q.push_back(e);
    endtask

    // Inputs are already driven; queue the expectation, take the edge, compare.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("gnt",      32'(gnt),      32'(e.gnt));
        check_val("busy",     32'(busy),     32'(e.busy));
        check_val("shared_q", 32'(shared_q), 32'(e.q));
        check_val("timeout",  32'(timeout),  32'(e.to));
    endtask

    task automatic set_lane(input int lane, input logic [DW-1:0] val);
        wr_data[lane*DW +: DW] = val;
    endtask

    function automatic int owner_of(input logic [NREQ-1:0] g);
        int o;
        o = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) o = i;
        return o;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Waits (bounded) for any grant; returns cycles spent waiting.
    task automatic wait_grant(input string tag, output int waited);
        waited = 0;
        while (gnt == '0 && waited < 12) begin
            cycle();
            waited++;
        end
        if (gnt == '0) check_val({tag, "_grant_timeout"}, 32'(gnt), 32'hFFFF_FFFF);
    endtask

    int order[$];
    int waited;
    int high_cnt;
    int to_cnt;
    int o;

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        req     = '0;
        wr_en   = '0;
        wr_data = '0;
        model_reset();
        #1;
        check_val("rst_gnt",  32'(gnt),      32'h0);
        check_val("rst_busy", 32'(busy),     32'h0);
        check_val("rst_q",    32'(shared_q), 32'h0);
        check_val("rst_to",   32'(timeout),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // reset mid-grant
        req = 4'b0100;
        cycle();
        check_val("mid_gnt2", 32'(gnt), 32'h4);
        wr_en = 4'b0100;
        set_lane(2, 8'h3C);
        cycle();
        check_val("mid_q3c", 32'(shared_q), 32'h3C);
        wr_en = '0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_val("async_gnt",  32'(gnt),      32'h0);
        check_val("async_busy", 32'(busy),     32'h0);
        check_val("async_q",    32'(shared_q), 32'h0);
        rst = 1'b0;
        req = 4'b0110;
        cycle();
        check_val("post_rst_gnt", 32'(gnt), 32'h2);
        req = '0;
        cycle();

        // writes with no grant are ignored
        wr_en = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_lane(i, 8'hF0 + 8'(i));
        cycle();
        check_val("idle_wr_q", 32'(shared_q), 32'h0);
        wr_en = '0;

        // single requester
        to_cnt = 0;
        req = 4'b0001;
        cycle();
        check_val("single_gnt", 32'(gnt), 32'h1);
        wr_en = 4'b0001;
        set_lane(0, 8'hA5);
        cycle();
        if (timeout) to_cnt++;
        wr_en = '0;
        req = '0;
        cycle();
        if (timeout) to_cnt++;
        check_val("single_q",    32'(shared_q), 32'hA5);
        check_val("single_drop", 32'(gnt),      32'h0);
        cycle();
        if (timeout) to_cnt++;
        check_val("single_to", 32'(to_cnt), 32'h0);

        // round robin from ptr=0
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant("rr", waited);
            check_val("rr_gap", 32'(waited), 32'h1);
            o = owner_of(gnt);
            order.push_back(o);
            cycle();
            if (o >= 0) req[o] = 1'b0;
            cycle();
            check_val("rr_release", 32'(gnt), 32'h0);
            if (o >= 0) req[o] = 1'b1;
        end
        for (int g = 0; g < 5; g++) check_val("rr_order", 32'(order[g]), 32'(g % NREQ));
        req = '0;
        cycle();
        cycle();

        // forced release; ptr is 1 here, req[3] also waiting
        req = 4'b1010;
        wait_grant("force", waited);
        check_val("force_gnt1", 32'(gnt), 32'h2);
        high_cnt = 1;
        to_cnt   = 0;
        for (int t = 0; t < 20 && gnt[1]; t++) begin
            cycle();
            if (timeout) to_cnt++;
            if (gnt[1]) high_cnt++;
            else check_val("force_to_at_drop", 32'(timeout), 32'h1);
        end
        check_val("force_hold_len", 32'(high_cnt), 32'(MAX_HOLD));
        cycle();
        if (timeout) to_cnt++;
        check_val("force_to_count", 32'(to_cnt), 32'h1);
        check_val("force_next_gnt", 32'(gnt), 32'h8);
        req = 4'b0010;
        cycle();
        cycle();
        req = '0;
        for (int t = 0; t < 12 && gnt != '0; t++) cycle();
        cycle();

        // non-owner writes blocked
        do_reset();
        req = 4'b0100;
        cycle();
        check_val("blk_gnt", 32'(gnt), 32'h4);
        wr_en = 4'b0100;
        set_lane(2, 8'h5C);
        cycle();
        wr_en = 4'b1001;
        set_lane(0, 8'h11);
        set_lane(3, 8'h33);
        set_lane(2, 8'hEE);
        cycle();
        check_val("blk_q", 32'(shared_q), 32'h5C);
        wr_en = 4'b0100;
        set_lane(2, 8'h7E);
        cycle();
        check_val("own_q", 32'(shared_q), 32'h7E);
        wr_en = '0;
        req = '0;
        cycle();
        cycle();

        // request drop on the hold-limit cycle
        req = 4'b0001;
        cycle();
        check_val("sim_gnt", 32'(gnt), 32'h1);
        for (int t = 0; t < MAX_HOLD - 1; t++) cycle();
        check_val("sim_still", 32'(gnt), 32'h1);
        req = '0;
        cycle();
        check_val("sim_gnt0", 32'(gnt),     32'h0);
        check_val("sim_to0",  32'(timeout), 32'h0);
        cycle();

        // randomized traffic, model-checked each edge
        for (int t = 0; t < 300; t++) begin
            req     = NREQ'($urandom);
            wr_en   = NREQ'($urandom);
            wr_data = (NREQ*DW)'({$urandom, $urandom});
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
